// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply and restoring divide,
// one radix-2 step per cycle, with architectural HI/LO and MF*/MT* access.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic logic [WIDTH-1:0] fix_sign32(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign64(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v < 0) ? fix_sign32(v, 1'b1) : v;
  endfunction

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic [2*WIDTH-1:0]     acc_p1;
  logic [WIDTH-1:0]       opnd_p1;
  logic                   is_div_p1, neg_q_p1, neg_r_p1, div_zero_p1;

  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic                   is_signed, is_muldiv, is_listed, start;
  logic [WIDTH:0]         mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0]     acc_next, mul_res;
  logic [WIDTH-1:0]       res_hi, res_lo;

  assign rs_s      = rs_val;
  assign rt_s      = rt_val;
  assign is_signed = ~funct[0];
  assign is_muldiv = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
  assign is_listed = is_muldiv || (funct == F_MFHI) || (funct == F_MTHI) ||
                     (funct == F_MFLO) || (funct == F_MTLO);
  assign busy      = (state != IDLE);
  assign stall     = ex_valid & busy & is_listed;
  assign start     = (state == IDLE) & ex_valid & is_muldiv;

  always_comb begin
    mf_data = '0;
    if (funct == F_MFHI)      mf_data = hi_out;
    else if (funct == F_MFLO) mf_data = lo_out;
  end

  // Step datapath: multiply keeps {partial, multiplier} and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    mul_sum   = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (acc_p1[0] ? {1'b0, opnd_p1} : '0);
    div_trial = {acc_p1[2*WIDTH-1:WIDTH], acc_p1[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_p1};
    if (!is_div_p1)
      acc_next = {mul_sum, acc_p1[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_next = {div_trial[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b0};
    else
      acc_next = {div_diff[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b1};
  end

  // Result stage: sign correction of magnitudes; divide-by-zero keeps the dividend in HI.
  always_comb begin
    mul_res = fix_sign64(acc_p1, neg_q_p1);
    if (!is_div_p1) begin
      res_hi = mul_res[2*WIDTH-1:WIDTH];
      res_lo = mul_res[WIDTH-1:0];
    end else if (div_zero_p1) begin
      res_hi = fix_sign32(acc_p1[2*WIDTH-1:WIDTH], neg_r_p1);
      res_lo = '1;
    end else begin
      res_hi = fix_sign32(acc_p1[2*WIDTH-1:WIDTH], neg_r_p1);
      res_lo = fix_sign32(acc_p1[WIDTH-1:0], neg_q_p1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      hi_out <= '0;
      lo_out <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (funct == F_MTHI) hi_out <= rs_val;
            if (funct == F_MTLO) lo_out <= rs_val;
            if (is_muldiv) begin
              state <= RUN;
              count <= '0;
            end
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (count == LAST_STEP) state <= FIN;
        end
        FIN: begin
          hi_out <= res_hi;
          lo_out <= res_lo;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture at accept, then one step per RUN cycle.
  always_ff @(posedge clock) begin
    if (start) begin
      is_div_p1   <= funct[1];
      neg_q_p1    <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      neg_r_p1    <= is_signed & rs_val[WIDTH-1];
      div_zero_p1 <= (rt_val == '0);
      if (funct[1]) begin
        acc_p1  <= {{WIDTH{1'b0}}, mag(rs_s, is_signed)};
        opnd_p1 <= mag(rt_s, is_signed);
      end else begin
        acc_p1  <= {{WIDTH{1'b0}}, mag(rt_s, is_signed)};
        opnd_p1 <= mag(rs_s, is_signed);
      end
    end else if (state == RUN) begin
      acc_p1 <= acc_next;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases plus random MULT/DIV traffic
// against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic [31:0] hi_out, lo_out, mf_data;
  logic        busy, stall, done;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .hi_out(hi_out), .lo_out(lo_out),
    .mf_data(mf_data), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      6'h18: begin q = sa * sb; p = q; return p; end
      6'h19: return ua * ub;
      6'h1A: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      6'h1B: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        p = {ua % ub, 32'h0} | (ua / ub);
        return p;
      end
      default: return 64'h0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no operation outstanding", hi_out, lo_out);
      end else begin
        chk("muldiv_result", {hi_out, lo_out}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
    ex_valid = 1'b1;
    funct    = f;
    rs_val   = a;
    rt_val   = b;
    if (expect_res) exp_q.push_back(model(f, a, b));
    step();
    ex_valid = 1'b0;
    funct    = 6'h00;
  endtask

  // Called just after the accept edge; returns after the done cycle has been checked.
  task automatic wait_done(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'd33);
    chk({name, "_done_high"}, {63'h0, done}, 64'h1);
    step();
    chk({name, "_done_one_cycle"}, {63'h0, done}, 64'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] e;
    logic [5:0]  f;
    int          bad;
    int          n;
    reset = 1'b1; ex_valid = 1'b0; funct = 6'h0; rs_val = 0; rt_val = 0;
    step(); step();
    reset = 1'b0;

    // Reset state with MFHI presented
    ex_valid = 1'b1; funct = 6'h10;
    #1;
    chk("reset_mf_data", {32'h0, mf_data}, 64'h0);
    chk("reset_ctrl", {61'h0, busy, stall, done}, 64'h0);
    chk("reset_hilo", {hi_out, lo_out}, 64'h0);
    ex_valid = 1'b0; funct = 6'h0;
    step();

    // Ignored requests: unlisted funct and ex_valid=0
    ex_valid = 1'b1; funct = 6'h20; rs_val = 32'h1234; step();
    ex_valid = 1'b0; funct = 6'h18; rs_val = 3; rt_val = 4; step();
    chk("ignored_busy", {63'h0, busy}, 64'h0);
    chk("ignored_hilo", {hi_out, lo_out}, 64'h0);
    funct = 6'h0;

    // MTLO / MTHI in idle, then MFLO
    issue(6'h13, 32'hCAFEF00D, 0, 0);
    chk("mtlo_lo", {32'h0, lo_out}, {32'h0, 32'hCAFEF00D});
    chk("mtlo_not_busy", {63'h0, busy}, 64'h0);
    issue(6'h11, 32'h0BADBEEF, 0, 0);
    chk("mthi_hi", {32'h0, hi_out}, {32'h0, 32'h0BADBEEF});
    funct = 6'h12; #1;
    chk("mflo_idle", {32'h0, mf_data}, {32'h0, 32'hCAFEF00D});
    funct = 6'h0;

    // Directed arithmetic corners
    issue(6'h18, 32'hFFFFFFFE, 32'd3, 1);         wait_done("mult_neg");
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);  wait_done("multu_max");
    issue(6'h1A, 32'hFFFFFFF9, 32'd2, 1);         wait_done("div_neg7");
    issue(6'h1B, 32'd100, 32'd0, 1);              wait_done("divu_zero");
    issue(6'h1A, 32'hFFFFFFF9, 32'd0, 1);         wait_done("div_zero_neg");
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF, 1);  wait_done("div_ovf");

    // MFLO held behind a DIV: stalls until the done cycle, then shows the new LO
    e = model(6'h1B, 32'd1000, 32'd7);
    issue(6'h1B, 32'd1000, 32'd7, 1);
    ex_valid = 1'b1; funct = 6'h12;
    bad = 0; n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (stall !== 1'b1) bad++;
      n++;
      step();
    end
    chk("mflo_stall_while_busy", 64'(bad), 64'h0);
    chk("mflo_busy_cycles", 64'(n), 64'd33);
    chk("mflo_stall_released", {63'h0, stall}, 64'h0);
    chk("mflo_new_lo", {32'h0, mf_data}, {32'h0, e[31:0]});
    ex_valid = 1'b0; funct = 6'h0;
    step();

    // MTHI while busy: held off, then applied at the first idle edge
    e = model(6'h18, 32'd9, 32'hFFFFFFFF);
    issue(6'h18, 32'd9, 32'hFFFFFFFF, 1);
    ex_valid = 1'b1; funct = 6'h11; rs_val = 32'h55AA1234; #1;
    chk("mthi_busy_stall", {63'h0, stall}, 64'h1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("mthi_busy_cycles", 64'(n), 64'd33);
    step();
    ex_valid = 1'b0; funct = 6'h0;
    chk("mthi_applied", {hi_out, lo_out}, {32'h55AA1234, e[31:0]});

    // Reset 10 cycles into a MULT aborts it: no result, no done
    issue(6'h18, 32'd123, 32'd456, 0);
    repeat (10) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_hilo", {hi_out, lo_out}, 64'h0);
    repeat (30) step();
    chk("abort_no_late_busy", {63'h0, busy}, 64'h0);
    issue(6'h18, 32'd5, 32'd6, 1);
    wait_done("mult_after_abort");
    chk("mult_after_abort_hilo", {hi_out, lo_out}, {32'h0, 32'd30});

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: f = 6'h18;
        1: f = 6'h19;
        2: f = 6'h1A;
        default: f = 6'h1B;
      endcase
      issue(f, pick(), pick(), 1);
      wait_done("rand");
    end

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
